// File: rtl/uart_pkg.sv
// Shared definitions for the MIO UART transmitter: FSM states, status word
// bit positions and bus command bits.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    localparam int ST_EMPTY  = 4;
    localparam int ST_FULL   = 5;
    localparam int ST_BUSY   = 6;
    localparam int ST_OVF    = 7;
    localparam int CMD_FLUSH = 9;

    function automatic logic [31:0] pack_status(
        input logic [3:0] cnt,
        input logic       empty,
        input logic       full,
        input logic       busy,
        input logic       ovf
    );
        logic [31:0] s;
        s           = 32'd0;
        s[3:0]      = cnt;
        s[ST_EMPTY] = empty;
        s[ST_FULL]  = full;
        s[ST_BUSY]  = busy;
        s[ST_OVF]   = ovf;
        return s;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with flush; the head is readable combinationally and
// the post-edge occupancy is exported so the owner can register its status.
module uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    count_next,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]    count_reg;
    logic             push_ok, pop_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    // A full FIFO refuses a push even when a pop frees a slot on the same edge.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_comb begin
        rd_ptr_next = rd_ptr_reg + AW'(pop_ok);
        wr_ptr_next = wr_ptr_reg + AW'(push_ok);
        count_next  = count_reg + CW'(push_ok) - CW'(pop_ok);
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr_reg] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_mio.sv
// Bus-writable 8N1 UART transmitter: queues written bytes, serialises them on
// txd and exposes a registered status word and level interrupt.
module uart_tx_mio
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        EN,
    input  logic [31:0] P_Data,
    output logic [31:0] status_out,
    output logic        txd,
    output logic        tx_busy,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(BAUD_DIV);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(BAUD_DIV - 1);

    tx_state_t     state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [2:0]    bitcnt_reg, bitcnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          txd_reg, txd_next;
    logic          overflow_reg, overflow_next;
    logic [31:0]   status_reg;
    logic          irq_reg;

    logic          push, flush, pop;
    logic [7:0]    head;
    logic [CW-1:0] count, count_next;
    logic          full, empty;
    logic          unused_bus_bits;

    assign push  = EN & ~P_Data[CMD_FLUSH];
    assign flush = EN &  P_Data[CMD_FLUSH];
    assign unused_bus_bits = ^{P_Data[31:10], P_Data[8], count};

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (RSTN),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .din        (P_Data[7:0]),
        .dout       (head),
        .count      (count),
        .count_next (count_next),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        state_next  = state_reg;
        timer_next  = (timer_reg == '0) ? '0 : timer_reg - TW'(1);
        bitcnt_next = bitcnt_reg;
        shift_next  = shift_reg;
        txd_next    = txd_reg;
        pop         = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                timer_next = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = head;
                    txd_next   = 1'b0;
                    timer_next = TIMER_LOAD;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (timer_reg == '0) begin
                    txd_next    = shift_reg[0];
                    shift_next  = {1'b0, shift_reg[7:1]};
                    bitcnt_next = 3'd0;
                    timer_next  = TIMER_LOAD;
                    state_next  = S_DATA;
                end
            end
            S_DATA: begin
                if (timer_reg == '0) begin
                    timer_next = TIMER_LOAD;
                    if (bitcnt_reg == 3'd7) begin
                        txd_next   = 1'b1;
                        state_next = S_STOP;
                    end else begin
                        txd_next    = shift_reg[0];
                        shift_next  = {1'b0, shift_reg[7:1]};
                        bitcnt_next = bitcnt_reg + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Chain straight into the next start bit so queued bytes leave without an idle gap.
                if (timer_reg == '0) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = head;
                        txd_next   = 1'b0;
                        timer_next = TIMER_LOAD;
                        state_next = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        overflow_next = overflow_reg;
        if (flush) begin
            overflow_next = 1'b0;
        end else if (push && full) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_reg    <= S_IDLE;
            timer_reg    <= '0;
            bitcnt_reg   <= '0;
            shift_reg    <= '0;
            txd_reg      <= 1'b1;
            overflow_reg <= 1'b0;
            status_reg   <= pack_status(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            irq_reg      <= 1'b1;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            bitcnt_reg   <= bitcnt_next;
            shift_reg    <= shift_next;
            txd_reg      <= txd_next;
            overflow_reg <= overflow_next;
            // Built from next-state values so the word matches the state this edge produces.
            status_reg   <= pack_status(4'(count_next), count_next == '0,
                                        count_next == CW'(FIFO_DEPTH),
                                        state_next != S_IDLE, overflow_next);
            irq_reg      <= (count_next == '0) && (state_next == S_IDLE);
        end
    end

    assign status_out = status_reg;
    assign txd        = txd_reg;
    assign tx_busy    = status_reg[ST_BUSY];
    assign irq        = irq_reg;

endmodule

// File: tb/tb_uart_tx_mio.sv
// Directed and random bench for uart_tx_mio, checked cycle by cycle against
// a frame-timing reference model of the transmitter.
module tb_uart_tx_mio;
    localparam int BAUD  = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * BAUD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] pdata;
    logic [31:0] status_out;
    logic        txd, tx_busy, irq;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: queue contents, the byte on the line and its start edge.
    logic [7:0] m_q[$];
    bit         m_active;
    int         m_start, m_end;
    logic [7:0] m_byte;
    bit         m_ovf;

    uart_tx_mio #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .RSTN       (rst_n),
        .EN         (en),
        .P_Data     (pdata),
        .status_out (status_out),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %h, required %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active = 0;
        m_ovf    = 0;
        m_start  = 0;
        m_end    = 0;
        m_byte   = 8'h00;
    endtask

    task automatic model_step();
        int  pre;
        bit  do_pop;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pre    = m_q.size();
        do_pop = 0;
        if (!m_active) begin
            if (pre != 0) do_pop = 1;
        end else if (cyc == m_end) begin
            if (pre != 0) do_pop = 1;
            else          m_active = 0;
        end
        if (do_pop) begin
            m_byte   = m_q.pop_front();
            m_active = 1;
            m_start  = cyc;
            m_end    = cyc + FRAME;
        end
        if (en) begin
            if (pdata[9]) begin
                m_q.delete();
                m_ovf = 0;
            end else if (pre == DEPTH) begin
                m_ovf = 1;
            end else begin
                m_q.push_back(pdata[7:0]);
            end
        end
    endtask

    function automatic logic exp_txd();
        int b;
        if (!m_active) return 1'b1;
        b = (cyc - m_start) / BAUD;
        if (b == 0) return 1'b0;
        if (b >= 9) return 1'b1;
        return m_byte[b-1];
    endfunction

    task automatic check_outputs();
        logic [31:0] st;
        int          n;
        n             = m_q.size();
        st            = 32'd0;
        st[3:0]       = 4'(n);
        st[4]         = (n == 0);
        st[5]         = (n == DEPTH);
        st[6]         = m_active;
        st[7]         = m_ovf;
        check("status", status_out, st);
        check("txd", {31'd0, txd}, {31'd0, exp_txd()});
        check("tx_busy", {31'd0, tx_busy}, {31'd0, m_active});
        check("irq", {31'd0, irq}, {31'd0, (n == 0) && !m_active});
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check_outputs();
        en    = 1'b0;
        pdata = 32'd0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [7:0] b);
        en    = 1'b1;
        pdata = {24'd0, b};
        tick();
    endtask

    task automatic flush_cmd();
        en    = 1'b1;
        pdata = 32'h0000_0200;
        tick();
    endtask

    task automatic wait_pre_end();
        int guard;
        guard = 0;
        while (cyc + 1 != m_end && guard < 100) begin
            tick();
            guard++;
        end
        check("wait_frame_end", {31'd0, guard < 100}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        pdata = 32'd0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("reset_status", status_out, 32'h10);
        check("reset_txd", {31'd0, txd}, 32'd1);
        check("reset_irq", {31'd0, irq}, 32'd1);
        ticks(2);
        rst_n = 1'b1;
        ticks(2);

        // 1: single frame, start bit from the edge after the write
        wr(8'h55);
        check("t1_txd_idle_at_E", {31'd0, txd}, 32'd1);
        tick();
        check("t1_start_bit", {31'd0, txd}, 32'd0);
        check("t1_busy", {31'd0, tx_busy}, 32'd1);
        ticks(FRAME);
        check("t1_irq_back", {31'd0, irq}, 32'd1);
        ticks(3);

        // 2: back-to-back frames
        wr(8'hA5);
        wr(8'h3C);
        ticks(2 * FRAME + 2);
        check("t2_idle", {31'd0, tx_busy}, 32'd0);

        // 3: fill the FIFO, overflow on the 10th write, then drain
        for (int i = 0; i < 9; i++) wr(8'($urandom_range(0, 255)));
        check("t3_full", {31'd0, status_out[5]}, 32'd1);
        check("t3_count", {28'd0, status_out[3:0]}, 32'd8);
        wr(8'hEE);
        check("t3_ovf", {31'd0, status_out[7]}, 32'd1);
        ticks(9 * FRAME + 5);
        check("t3_drained_irq", {31'd0, irq}, 32'd1);

        // 4: flush mid-frame with 3 bytes queued
        for (int i = 0; i < 4; i++) wr(8'($urandom_range(0, 255)));
        ticks(10);
        check("t4_count_before", {28'd0, status_out[3:0]}, 32'd3);
        flush_cmd();
        check("t4_count", {28'd0, status_out[3:0]}, 32'd0);
        check("t4_ovf", {31'd0, status_out[7]}, 32'd0);
        ticks(FRAME);
        check("t4_irq", {31'd0, irq}, 32'd1);

        // 5: asynchronous reset in the data phase
        wr(8'($urandom_range(0, 255)));
        ticks(12);
        rst_n = 1'b0;
        #1;
        check("t5_txd", {31'd0, txd}, 32'd1);
        check("t5_busy", {31'd0, tx_busy}, 32'd0);
        check("t5_status", status_out, 32'h10);
        ticks(2);
        rst_n = 1'b1;
        wr(8'($urandom_range(0, 255)));
        ticks(FRAME + 3);

        // 6: pushes coinciding with the STOP->START pop
        for (int i = 0; i < 9; i++) wr(8'($urandom_range(0, 255)));
        wait_pre_end();
        wr(8'h77);
        check("t6_ovf", {31'd0, status_out[7]}, 32'd1);
        check("t6_count7", {28'd0, status_out[3:0]}, 32'd7);
        flush_cmd();
        for (int i = 0; i < 3; i++) wr(8'($urandom_range(0, 255)));
        check("t6_count3_pre", {28'd0, status_out[3:0]}, 32'd3);
        wait_pre_end();
        wr(8'h99);
        check("t6_count3", {28'd0, status_out[3:0]}, 32'd3);
        ticks(5 * FRAME);

        // Random traffic with occasional flushes
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                en    = 1'b1;
                pdata = {24'd0, 8'($urandom_range(0, 255))};
            end else if (r == 8) begin
                en    = 1'b1;
                pdata = 32'h0000_0200;
            end
            tick();
        end
        ticks(10 * FRAME);
        check("final_irq", {31'd0, irq}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
